drap_regfile_mp: RTL and testbench

DRAP_REGFILE_MP -- requirements
Module: drap_regfile_mp

---
 rtl/drap_pkg.sv | 13 +
 rtl/drap_scoreboard.sv | 51 +++++
 rtl/drap_regfile_mp.sv | 108 ++++++++++
 tb/tb_drap_regfile_mp.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/drap_pkg.sv
// rtl/drap_pkg.sv - shared width defaults and read-port limits for the drap register file
package drap_pkg;

    localparam int DRAP_B_DEFAULT = 32;
    localparam int DRAP_W_DEFAULT = 5;
    localparam int DRAP_NR_MIN    = 1;
    localparam int DRAP_NR_MAX    = 4;

    function automatic int drap_depth(input int w);
        return 1 << w;
    endfunction

endpackage

// File: rtl/drap_scoreboard.sv
// rtl/drap_scoreboard.sv - one busy bit per register; a set beats a clear to the same register
module drap_scoreboard
    import drap_pkg::*;
#(
    parameter int W       = DRAP_W_DEFAULT,
    parameter int ZERO_R0 = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     set_en,
    input  logic [W-1:0]             set_addr,
    input  logic                     clr0_en,
    input  logic [W-1:0]             clr0_addr,
    input  logic                     clr1_en,
    input  logic [W-1:0]             clr1_addr,
    output logic [drap_depth(W)-1:0] busy
);

    localparam int DEPTH = drap_depth(W);

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;
    logic             set_ok;

    // Register 0 can never have a producer outstanding when it is hardwired
    assign set_ok = set_en && !((ZERO_R0 != 0) && (set_addr == '0));

    always_comb begin
        busy_d = busy_q;
        if (clr0_en) begin
            busy_d[clr0_addr] = 1'b0;
        end
        if (clr1_en) begin
            busy_d[clr1_addr] = 1'b0;
        end
        if (set_ok) begin
            busy_d[set_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;

endmodule

// File: rtl/drap_regfile_mp.sv
// rtl/drap_regfile_mp.sv - two-write, NR-read register file with forwarding and busy scoreboard
module drap_regfile_mp
    import drap_pkg::*;
#(
    parameter int B       = DRAP_B_DEFAULT,
    parameter int W       = DRAP_W_DEFAULT,
    parameter int NR      = 3,
    parameter int BYPASS  = 1,
    parameter int ZERO_R0 = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wr_en0,
    input  logic [W-1:0]    w_addr0,
    input  logic [B-1:0]    w_data0,
    input  logic            wr_en1,
    input  logic [W-1:0]    w_addr1,
    input  logic [B-1:0]    w_data1,
    input  logic [NR*W-1:0] r_addr,
    output logic [NR*B-1:0] r_data,
    output logic [NR-1:0]   r_busy,
    input  logic            set_en,
    input  logic [W-1:0]    set_addr
);

    localparam int DEPTH = drap_depth(W);

    if (NR < DRAP_NR_MIN || NR > DRAP_NR_MAX) begin : g_nr_check
        $error("drap_regfile_mp: NR outside supported range");
    end

    logic [B-1:0]     mem_q [DEPTH];
    logic [DEPTH-1:0] busy;
    logic             we0;
    logic             we1;

    // Writes aimed at a hardwired register 0 are dropped before storage, scoreboard and bypass
    assign we0 = wr_en0 && !((ZERO_R0 != 0) && (w_addr0 == '0));
    assign we1 = wr_en1 && !((ZERO_R0 != 0) && (w_addr1 == '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (we0) begin
                mem_q[w_addr0] <= w_data0;
            end
            if (we1) begin
                mem_q[w_addr1] <= w_data1;
            end
        end
    end

    drap_scoreboard #(
        .W       (W),
        .ZERO_R0 (ZERO_R0)
    ) u_scoreboard (
        .clk       (clk),
        .rst_n     (rst_n),
        .set_en    (set_en),
        .set_addr  (set_addr),
        .clr0_en   (we0),
        .clr0_addr (w_addr0),
        .clr1_en   (we1),
        .clr1_addr (w_addr1),
        .busy      (busy)
    );

    for (genvar k = 0; k < NR; k++) begin : g_rd
        logic [W-1:0] ra;
        logic [B-1:0] rd;
        logic         rb;
        logic         hit0;
        logic         hit1;
        logic         set_hit;

        assign ra      = r_addr[k*W +: W];
        assign hit0    = we0 && (w_addr0 == ra);
        assign hit1    = we1 && (w_addr1 == ra);
        assign set_hit = set_en && (set_addr == ra);

        always_comb begin
            rd = mem_q[ra];
            rb = busy[ra];
            if (BYPASS != 0) begin
                if (hit1) begin
                    rd = w_data1;
                end else if (hit0) begin
                    rd = w_data0;
                end
                // A same-cycle completion hides the busy bit unless a new producer claims it
                if ((hit0 || hit1) && !set_hit) begin
                    rb = 1'b0;
                end
            end
            if (!rst_n || ((ZERO_R0 != 0) && (ra == '0))) begin
                rd = '0;
                rb = 1'b0;
            end
        end

        assign r_data[k*B +: B] = rd;
        assign r_busy[k]        = rb;
    end

endmodule

// File: tb/tb_drap_regfile_mp.sv
// tb/tb_drap_regfile_mp.sv - scoreboard bench running bypass and non-bypass instances side by side
module tb_drap_regfile_mp;

    localparam int B  = 32;
    localparam int W  = 5;
    localparam int NR = 3;
    localparam int D  = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            wr_en0, wr_en1, set_en;
    logic [W-1:0]    w_addr0, w_addr1, set_addr;
    logic [B-1:0]    w_data0, w_data1;
    logic [NR*W-1:0] r_addr;
    logic [NR*B-1:0] r_data_b, r_data_n;
    logic [NR-1:0]   r_busy_b, r_busy_n;

    always #5 clk = ~clk;

    drap_regfile_mp #(.B(B), .W(W), .NR(NR), .BYPASS(1), .ZERO_R0(1)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .wr_en0(wr_en0), .w_addr0(w_addr0), .w_data0(w_data0),
        .wr_en1(wr_en1), .w_addr1(w_addr1), .w_data1(w_data1),
        .r_addr(r_addr), .r_data(r_data_b), .r_busy(r_busy_b),
        .set_en(set_en), .set_addr(set_addr)
    );

    drap_regfile_mp #(.B(B), .W(W), .NR(NR), .BYPASS(0), .ZERO_R0(1)) dut_n (
        .clk(clk), .rst_n(rst_n),
        .wr_en0(wr_en0), .w_addr0(w_addr0), .w_data0(w_data0),
        .wr_en1(wr_en1), .w_addr1(w_addr1), .w_data1(w_data1),
        .r_addr(r_addr), .r_data(r_data_n), .r_busy(r_busy_n),
        .set_en(set_en), .set_addr(set_addr)
    );

    typedef struct {
        string        name;
        int           inst;
        int           port;
        logic [B-1:0] data;
        logic         busy;
    } exp_t;

    exp_t         q[$];
    int           checks   = 0;
    int           failures = 0;
    logic [B-1:0] m_mem [D];
    bit           m_busy [D];
    event         chk_now;

    function automatic logic [B-1:0] ref_data(int a, bit byp);
        if (!rst_n || a == 0) return '0;
        if (byp) begin
            if (wr_en1 && int'(w_addr1) == a) return w_data1;
            if (wr_en0 && int'(w_addr0) == a) return w_data0;
        end
        return m_mem[a];
    endfunction

    function automatic logic ref_busy(int a, bit byp);
        bit wr_hit;
        bit set_hit;
        if (!rst_n || a == 0) return 1'b0;
        wr_hit  = (wr_en1 && int'(w_addr1) == a) || (wr_en0 && int'(w_addr0) == a);
        set_hit = set_en && int'(set_addr) == a;
        if (byp && wr_hit && !set_hit) return 1'b0;
        return m_busy[a];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < D; i++) begin
            m_mem[i]  = '0;
            m_busy[i] = 1'b0;
        end
    endtask

    task automatic model_edge();
        if (!rst_n) begin
            model_clear();
        end else begin
            if (wr_en0 && w_addr0 != 0) begin
                m_mem[w_addr0]  = w_data0;
                m_busy[w_addr0] = 1'b0;
            end
            if (wr_en1 && w_addr1 != 0) begin
                m_mem[w_addr1]  = w_data1;
                m_busy[w_addr1] = 1'b0;
            end
            if (set_en && set_addr != 0) m_busy[set_addr] = 1'b1;
        end
    endtask

    task automatic expect_cycle(string name);
        int a;
        for (int k = 0; k < NR; k++) begin
            a = int'(r_addr[k*W +: W]);
            q.push_back('{name, 0, k, ref_data(a, 1'b1), ref_busy(a, 1'b1)});
            q.push_back('{name, 1, k, ref_data(a, 1'b0), ref_busy(a, 1'b0)});
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        wr_en0 = 1'b0; wr_en1 = 1'b0; set_en = 1'b0;
    endtask

    task automatic set_raddr(int a0, int a1, int a2);
        r_addr = {W'(a2), W'(a1), W'(a0)};
    endtask

    initial begin : monitor
        exp_t         e;
        logic [B-1:0] got_d;
        logic         got_b;
        forever begin
            @(negedge clk or chk_now);
            while (q.size() > 0) begin
                e     = q.pop_front();
                got_d = (e.inst == 0) ? r_data_b[e.port*B +: B] : r_data_n[e.port*B +: B];
                got_b = (e.inst == 0) ? r_busy_b[e.port] : r_busy_n[e.port];
                checks++;
                if (got_d !== e.data || got_b !== e.busy) begin
                    failures++;
                    $display("FAIL %s inst=%0d port=%0d data got=%h exp=%h busy got=%b exp=%b",
                             e.name, e.inst, e.port, got_d, e.data, got_b, e.busy);
                end
            end
        end
    end

    initial begin : stimulus
        rst_n = 1'b0;
        idle();
        w_addr0 = '0; w_addr1 = '0; set_addr = '0;
        w_data0 = '0; w_data1 = '0;
        set_raddr(0, 1, 2);
        model_clear();
        #1;
        expect_cycle("rst_init");
        step();
        step();
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            set_raddr((3*i) % D, (3*i+1) % D, (3*i+2) % D);
            expect_cycle("post_rst_zero");
            step();
        end

        wr_en0 = 1'b1; w_addr0 = 5'd5; w_data0 = 32'h1111_1111;
        wr_en1 = 1'b1; w_addr1 = 5'd5; w_data1 = 32'h2222_2222;
        set_raddr(5, 6, 5);
        expect_cycle("dual_wr_same_cycle");
        step();
        idle();
        expect_cycle("dual_wr_stored");
        step();

        wr_en0 = 1'b1; w_addr0 = 5'd0; w_data0 = 32'hDEAD_BEEF;
        wr_en1 = 1'b1; w_addr1 = 5'd0; w_data1 = 32'hDEAD_BEEF;
        set_raddr(0, 0, 5);
        expect_cycle("r0_write_same");
        step();
        idle();
        expect_cycle("r0_write_after");
        step();

        set_en = 1'b1; set_addr = 5'd7;
        set_raddr(0, 7, 7);
        expect_cycle("set7_issue");
        step();
        wr_en0 = 1'b1; w_addr0 = 5'd7; w_data0 = 32'h0000_0777;
        expect_cycle("set7_and_clr");
        step();
        idle();
        expect_cycle("set7_still_busy");
        step();
        wr_en1 = 1'b1; w_addr1 = 5'd7; w_data1 = 32'h0000_7007;
        expect_cycle("clr7_same_cycle");
        step();
        idle();
        expect_cycle("clr7_after");
        step();

        wr_en0 = 1'b1; w_addr0 = 5'd9; w_data0 = 32'hA5A5_A5A5;
        set_en = 1'b1; set_addr = 5'd3;
        set_raddr(9, 3, 0);
        expect_cycle("wr9");
        step();
        idle();
        expect_cycle("rd9_before_rst");
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        model_clear();
        expect_cycle("rst_mid_cycle");
        ->chk_now;
        #1;
        step();
        wr_en0 = 1'b1; w_addr0 = 5'd3; w_data0 = 32'h3333_3333;
        set_en = 1'b1; set_addr = 5'd3;
        expect_cycle("rst_hold_discard");
        step();
        rst_n = 1'b1;
        wr_en0 = 1'b1; w_addr0 = 5'd4; w_data0 = 32'h4444_4444;
        set_en = 1'b0;
        set_raddr(3, 4, 9);
        expect_cycle("first_wr_after_rst");
        step();
        idle();
        expect_cycle("first_wr_stored");
        step();

        for (int n = 0; n < 400; n++) begin
            wr_en0   = 1'($urandom_range(0, 1));
            wr_en1   = 1'($urandom_range(0, 1));
            set_en   = 1'($urandom_range(0, 1));
            w_addr0  = W'($urandom_range(0, 7));
            w_addr1  = W'($urandom_range(0, 7));
            set_addr = W'($urandom_range(0, 7));
            w_data0  = $urandom();
            w_data1  = $urandom();
            set_raddr($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, D-1));
            expect_cycle("random");
            step();
        end

        idle();
        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL queue_drain left=%0d required=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
